// File: rtl/heartbeat_monitor.sv
// Heartbeat monitor: synchronises one CPU's PWM heartbeat, measures rising-to-rising period
// and qualifies a registered alive flag with hysteresis. Optional high-time check: HEARTBEAT_DUTY_CHECK_EN.
module heartbeat_monitor #(
    parameter int CNT_W      = 20,
    parameter int MIN_PERIOD = 45000,
    parameter int MAX_PERIOD = 55000,
    parameter int GOOD_N     = 4,
    parameter int BAD_N      = 2
`ifdef HEARTBEAT_DUTY_CHECK_EN
    ,
    parameter int MIN_HIGH   = 10000,
    parameter int MAX_HIGH   = 40000
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm,
    output logic             io,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             fault,
    output logic [1:0]       state
);

    localparam logic [1:0] ST_DEAD    = 2'd0;
    localparam logic [1:0] ST_QUALIFY = 2'd1;
    localparam logic [1:0] ST_ALIVE   = 2'd2;
    localparam logic [1:0] ST_SUSPECT = 2'd3;

    localparam int GW = $clog2(GOOD_N + 1);
    localparam int BW = $clog2(BAD_N + 1);

    localparam logic [CNT_W-1:0] MIN_P    = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] MAX_P    = CNT_W'(MAX_PERIOD);
    localparam logic [GW-1:0]    GOOD_TGT = GW'(GOOD_N);
    localparam logic [BW-1:0]    BAD_TGT  = BW'(BAD_N);

    function automatic logic in_window(input logic [CNT_W-1:0] v,
                                       input logic [CNT_W-1:0] lo,
                                       input logic [CNT_W-1:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Stage p0/p1: two-flop synchroniser; p2: previous synchronised sample for edge detect.
    // Left out of reset so a pin already high at reset is not mistaken for an edge.
    logic pwm_p0, pwm_p1, pwm_p2;

    always_ff @(posedge clk) begin
        pwm_p0 <= pwm;
        pwm_p1 <= pwm_p0;
        pwm_p2 <= pwm_p1;
    end

    // Event classification from the synchronised edge and the running period counter.
    logic             rise;
    logic             ref_seen;
    logic             meas;
    logic             timeout;
    logic             period_ok;
    logic             duty_ok;
    logic             good_evt;
    logic             bad_evt;
    logic [CNT_W-1:0] cnt;

    always_comb begin
        rise      = pwm_p1 & ~pwm_p2;
        meas      = rise & ref_seen;
        timeout   = ~rise & ref_seen & (cnt == MAX_P);
        period_ok = in_window(cnt, MIN_P, MAX_P);
        good_evt  = meas & period_ok & duty_ok;
        bad_evt   = (meas & ~(period_ok & duty_ok)) | timeout;
    end

`ifdef HEARTBEAT_DUTY_CHECK_EN
    localparam logic [CNT_W-1:0] MIN_H = CNT_W'(MIN_HIGH);
    localparam logic [CNT_W-1:0] MAX_H = CNT_W'(MAX_HIGH);

    logic             fall;
    logic             high_run;
    logic             fell;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] high_len;

    // high_len holds the high time of the pulse that began at the previous rise;
    // fell stays low when that pulse never ended, which fails the duty check.
    always_comb begin
        fall    = ~pwm_p1 & pwm_p2;
        duty_ok = fell & in_window(high_len, MIN_H, MAX_H);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            high_run <= 1'b0;
            fell     <= 1'b0;
            hcnt     <= '0;
            high_len <= '0;
        end else if (rise) begin
            high_run <= 1'b1;
            fell     <= 1'b0;
            hcnt     <= CNT_W'(1);
        end else begin
            if (high_run)
                hcnt <= sat_inc(hcnt);
            if (fall) begin
                high_run <= 1'b0;
                fell     <= high_run;
                high_len <= hcnt;
            end
        end
    end
`else
    assign duty_ok = 1'b1;
`endif

    // Period measurement: counter restarts on every rise and is parked at zero without a reference.
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_seen     <= 1'b0;
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
        end else begin
            period_valid <= meas;
            if (rise) begin
                ref_seen <= 1'b1;
                cnt      <= CNT_W'(1);
                if (ref_seen)
                    period <= cnt;
            end else if (timeout) begin
                ref_seen <= 1'b0;
                cnt      <= '0;
            end else if (ref_seen) begin
                cnt <= sat_inc(cnt);
            end
        end
    end

    // Health FSM: counters are cleared whenever a state is entered afresh.
    logic [1:0]    state_nx;
    logic [GW-1:0] good_cnt, good_nx, good_inc;
    logic [BW-1:0] bad_cnt, bad_nx, bad_inc;

    always_comb begin
        state_nx = state;
        good_nx  = good_cnt;
        bad_nx   = bad_cnt;
        good_inc = good_cnt + GW'(1);
        bad_inc  = bad_cnt + BW'(1);
        case (state)
            ST_DEAD, ST_QUALIFY: begin
                if (good_evt) begin
                    if (good_inc == GOOD_TGT) begin
                        state_nx = ST_ALIVE;
                        good_nx  = '0;
                        bad_nx   = '0;
                    end else begin
                        state_nx = ST_QUALIFY;
                        good_nx  = good_inc;
                    end
                end else if (bad_evt) begin
                    state_nx = ST_DEAD;
                    good_nx  = '0;
                end
            end
            ST_ALIVE, ST_SUSPECT: begin
                if (bad_evt) begin
                    if (bad_inc == BAD_TGT) begin
                        state_nx = ST_DEAD;
                        good_nx  = '0;
                        bad_nx   = '0;
                    end else begin
                        state_nx = ST_SUSPECT;
                        bad_nx   = bad_inc;
                    end
                end else if (good_evt) begin
                    state_nx = ST_ALIVE;
                    bad_nx   = '0;
                end
            end
            default: begin
                state_nx = ST_DEAD;
                good_nx  = '0;
                bad_nx   = '0;
            end
        endcase
    end

    // io is high in ALIVE and SUSPECT (state bit 1); fault marks its falling cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_DEAD;
            good_cnt <= '0;
            bad_cnt  <= '0;
            io       <= 1'b0;
            fault    <= 1'b0;
        end else begin
            state    <= state_nx;
            good_cnt <= good_nx;
            bad_cnt  <= bad_nx;
            io       <= state_nx[1];
            fault    <= io & ~state_nx[1];
        end
    end

endmodule

// File: tb/tb_heartbeat_monitor.sv
// Testbench for heartbeat_monitor: vector table, hand-written corner sequences and random
// pulse trains, all compared every cycle against a behavioural model of the health rules.
module tb_heartbeat_monitor;

    localparam int CNT_W      = 8;
    localparam int MIN_PERIOD = 8;
    localparam int MAX_PERIOD = 12;
    localparam int GOOD_N     = 3;
    localparam int BAD_N      = 2;
`ifdef HEARTBEAT_DUTY_CHECK_EN
    localparam int MIN_HIGH   = 2;
    localparam int MAX_HIGH   = 6;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             pwm = 1'b0;
    logic             io;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             fault;
    logic [1:0]       state;

    always #5 clk = ~clk;

    heartbeat_monitor #(
        .CNT_W(CNT_W), .MIN_PERIOD(MIN_PERIOD), .MAX_PERIOD(MAX_PERIOD),
        .GOOD_N(GOOD_N), .BAD_N(BAD_N)
`ifdef HEARTBEAT_DUTY_CHECK_EN
        , .MIN_HIGH(MIN_HIGH), .MAX_HIGH(MAX_HIGH)
`endif
    ) dut (
        .clk(clk), .rst(rst), .pwm(pwm), .io(io), .period(period),
        .period_valid(period_valid), .fault(fault), .state(state)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: works on the pin history as sampled at each clock edge and
    // applies the period/timeout/hysteresis rules directly in integer arithmetic.
    bit hist[$];
    int cyc = 0;
    bit m_ref = 0, m_hi_run = 0, m_fell = 0, m_alive = 0;
    int m_last = 0, m_high = 0, m_good = 0, m_bad = 0;
    int m_state = 0, m_period = 0;
    bit m_io = 0, m_pv = 0, m_fault = 0;
    bit chk_en = 0;
    int fault_cnt = 0;

    function automatic bit sample(input int back);
        if (hist.size() <= back) return 1'b0;
        return hist[hist.size() - 1 - back];
    endfunction

    task automatic model_step();
        bit rise, fall, good, bad;
        int gap;
        cyc++;
        hist.push_back(pwm);
        if (hist.size() > 8) void'(hist.pop_front());
        // pin sampled at edge n-2 reaches the edge detector for edge n
        rise = sample(2) && !sample(3);
        fall = !sample(2) && sample(3);
        good = 0; bad = 0; m_pv = 0; m_fault = 0;
        if (rst) begin
            m_ref = 0; m_hi_run = 0; m_fell = 0; m_alive = 0;
            m_good = 0; m_bad = 0; m_period = 0;
        end else begin
            gap = cyc - m_last;
            if (rise) begin
                if (m_ref) begin
                    m_period = gap;
                    m_pv = 1;
                    good = (gap >= MIN_PERIOD) && (gap <= MAX_PERIOD);
`ifdef HEARTBEAT_DUTY_CHECK_EN
                    if (!(m_fell && m_high >= MIN_HIGH && m_high <= MAX_HIGH)) good = 0;
`endif
                    bad = !good;
                end
                m_ref = 1; m_last = cyc; m_hi_run = 1; m_fell = 0;
            end else begin
                if (m_ref && gap == MAX_PERIOD) begin
                    bad = 1;
                    m_ref = 0;
                end
                if (fall && m_hi_run) begin
                    m_hi_run = 0;
                    m_fell = 1;
                    m_high = cyc - m_last;
                end
            end
            if (good) begin
                if (m_alive) m_bad = 0;
                else begin
                    m_good++;
                    if (m_good >= GOOD_N) begin m_alive = 1; m_good = 0; end
                end
            end else if (bad) begin
                if (m_alive) begin
                    m_bad++;
                    if (m_bad >= BAD_N) begin m_alive = 0; m_bad = 0; m_fault = 1; end
                end else begin
                    m_good = 0;
                end
            end
        end
        m_io = m_alive;
        m_state = m_alive ? ((m_bad > 0) ? 3 : 2) : ((m_good > 0) ? 1 : 0);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("model io", int'(io), int'(m_io));
            check("model state", int'(state), m_state);
            check("model period", int'(period), m_period);
            check("model period_valid", int'(period_valid), int'(m_pv));
            check("model fault", int'(fault), int'(m_fault));
            if (fault) fault_cnt++;
        end
    end

    // One pulse: pin high for hi cycles within per cycles; optional check 3 cycles after the rise.
    typedef struct {
        int per; int hi; bit chk; int st; int io_e; int p_e; int pv;
    } vec_t;

    task automatic apply(input vec_t v, input string tag);
        pwm = 1'b1;
        for (int i = 1; i <= v.per; i++) begin
            @(negedge clk);
            if (i == v.hi) pwm = 1'b0;
            if (i == 3 && v.chk) begin
                check($sformatf("%s state", tag), int'(state), v.st);
                check($sformatf("%s io", tag), int'(io), v.io_e);
                check($sformatf("%s period", tag), int'(period), v.p_e);
                check($sformatf("%s period_valid", tag), int'(period_valid), v.pv);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check($sformatf("%s io", tag), int'(io), 0);
        check($sformatf("%s state", tag), int'(state), 0);
        check($sformatf("%s period", tag), int'(period), 0);
        check($sformatf("%s period_valid", tag), int'(period_valid), 0);
        check($sformatf("%s fault", tag), int'(fault), 0);
    endtask

    vec_t tbl[16];
    vec_t seq[4];

    initial begin
        tbl = '{
            '{10, 5, 1, 0, 0,  0, 0},   // reference edge only
            '{10, 5, 1, 1, 0, 10, 1},
            '{10, 5, 1, 1, 0, 10, 1},
            '{10, 5, 1, 2, 1, 10, 1},   // third good period: alive
            '{ 6, 3, 1, 2, 1, 10, 1},
            '{10, 5, 1, 3, 1,  6, 1},   // short period: suspect
            '{10, 5, 1, 2, 1, 10, 1},
            '{12, 6, 1, 2, 1, 10, 1},
            '{ 8, 4, 1, 2, 1, 12, 1},   // exactly max
            '{ 7, 3, 1, 2, 1,  8, 1},   // exactly min
            '{10, 5, 1, 3, 1,  7, 1},   // one below min
            '{13, 6, 1, 2, 1, 10, 1},   // 13 times out
            '{20, 6, 1, 3, 1, 10, 0},   // ref edge after timeout; 20 times out again
            '{10, 5, 1, 0, 0, 10, 0},   // dead, ref edge only
            '{10, 5, 1, 1, 0, 10, 1},
            '{10, 5, 1, 1, 0, 10, 1}    // qualify, two good periods
        };

        repeat (4) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        chk_en = 1'b1;

        fault_cnt = 0;
        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));
        check("fault pulse count", fault_cnt, 1);

        // reset in the middle of qualification
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("midrst");
        apply('{10, 5, 1, 0, 0,  0, 0}, "post-reset ref");
        apply('{10, 5, 1, 1, 0, 10, 1}, "post-reset first");

        // random pulse trains, occasional stuck pin and resets
        for (int n = 0; n < 80; n++) begin
            vec_t v;
            v.chk = 0; v.st = 0; v.io_e = 0; v.p_e = 0; v.pv = 0;
            if ($urandom_range(0, 3) == 0) v.per = $urandom_range(4, 16);
            else v.per = $urandom_range(MIN_PERIOD, MAX_PERIOD);
            if ($urandom_range(0, 19) == 0) v.per = 30;
            if ($urandom_range(0, 2) == 0) v.hi = $urandom_range(1, v.per - 1);
            else v.hi = $urandom_range(2, 5);
            apply(v, "rand");
            if ($urandom_range(0, 24) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end

`ifdef HEARTBEAT_DUTY_CHECK_EN
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seq = '{
            '{10, 4, 1, 0, 0,  0, 0},
            '{10, 8, 1, 1, 0, 10, 1},   // high 4 accepted
            '{10, 4, 1, 0, 0, 10, 1},   // high 8 rejected
            '{10, 4, 1, 1, 0, 10, 1}
        };
        foreach (seq[i]) apply(seq[i], $sformatf("duty%0d", i));
`endif

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
